// File: rtl/mb_fetch_sequencer.sv
// Macroblock fetch sequencer: walks a frame's addresses, reads each
// macroblock from the bank memory and queues it for the compute unit.
module mb_fetch_sequencer #(
  parameter int LAST_ADDR   = 25560,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_data_ready,
  input  logic        i_MB_ready,
  input  logic [31:0] i_MB_flat,
  output logic [14:0] o_inq_addr,
  output logic        o_inqury_update,
  output logic        o_pix_valid,
  input  logic        i_pix_ready,
  output logic [31:0] o_pix_data,
  output logic [14:0] o_pix_addr,
  output logic        o_pix_last,
  output logic        o_frame_done,
  output logic        o_busy,
  output logic        o_timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WLO,
    S_WHI
  } state_t;

  state_t          r_state;
  logic [14:0]     r_addr;
  logic [TW-1:0]   r_wcnt;
  logic            r_dr_q;
  logic            r_done;
  logic            r_err;

  logic [31:0]     r_mem_data [DEPTH];
  logic [14:0]     r_mem_addr [DEPTH];
  logic            r_mem_last [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;

  logic w_full;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_last;
  logic w_start;
  logic w_tmo;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_issue = (r_state == S_REQ) && !w_full;
  assign w_push  = (r_state == S_WHI) && i_MB_ready;
  assign w_pop   = o_pix_valid && i_pix_ready;
  assign w_last  = (r_addr == 15'(LAST_ADDR));
  assign w_start = i_data_ready && !r_dr_q;
  assign w_tmo   = (r_wcnt == TW'(TIMEOUT_CYC - 1));

  // Request/capture sequencing, wait watchdog and frame status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wcnt  <= '0;
      r_dr_q  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_dr_q <= i_data_ready;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!w_full) begin
            r_wcnt  <= '0;
            r_state <= S_WLO;
          end
        end
        S_WLO: begin
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + TW'(1);
            if (!i_MB_ready)
              r_state <= S_WHI;
          end
        end
        S_WHI: begin
          if (i_MB_ready) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_addr  <= r_addr + 15'd1;
              r_state <= S_REQ;
            end
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide at any level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage; contents are only visible through a valid head.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= i_MB_flat;
      r_mem_addr[r_wptr] <= r_addr;
      r_mem_last[r_wptr] <= w_last;
    end
  end

  assign o_inq_addr      = r_addr;
  assign o_inqury_update = w_issue;
  assign o_pix_valid     = (r_cnt != '0);
  assign o_pix_data      = o_pix_valid ? r_mem_data[r_rptr] : '0;
  assign o_pix_addr      = o_pix_valid ? r_mem_addr[r_rptr] : '0;
  assign o_pix_last      = o_pix_valid && r_mem_last[r_rptr];
  assign o_frame_done    = r_done;
  assign o_busy          = (r_state != S_IDLE);
  assign o_timeout_err   = r_err;

endmodule
